// File: rtl/fft_pkg.sv
// Shared constants, FSM state type and beat tag type for the FFT stage controller.
package fft_pkg;

    localparam int NUM   = 16;
    localparam int DATA  = 128;
    localparam int COUNT = DATA / NUM;
    localparam int HALF  = COUNT / 2;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        TAIL,
        FLUSH
    } fft_ctrl_state_t;

    typedef struct packed {
        logic valid;
        logic sop;
        logic eop;
    } ctrl_tag_t;

endpackage

// File: rtl/ctrl_delay_line.sv
// LAT-deep shift register carrying each issued beat's {valid,sop,eop} tag
// from the issue point to the downstream status outputs.
module ctrl_delay_line
    import fft_pkg::*;
#(
    parameter int LAT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] din,
    output logic [2:0] dout,
    output logic       any_valid
);

    ctrl_tag_t pipe [LAT];

    // NOTE: non-blocking assignments let every stage sample its predecessor's old value.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: each stage is cleared so no stale valid tag escapes after reset.
            for (int i = 0; i < LAT; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= din;
            for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign dout = pipe[LAT-1];

    always_comb begin
        any_valid = 1'b0;
        for (int i = 0; i < LAT; i++) any_valid |= pipe[i].valid;
    end

endmodule

// File: rtl/fft_stage_ctrl.sv
// Beat sequencer for one radix-2 FFT stage: issues low results as the high half
// of a frame arrives, then the owed high results. Optional stats: FFT_CTRL_STATS_EN.
module fft_stage_ctrl #(
    parameter int NUM  = fft_pkg::NUM,
    parameter int DATA = fft_pkg::DATA,
    parameter int LAT  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic                    dp_sel,
    output logic                    dp_issue,
    output logic [$clog2(DATA)-1:0] dp_tw_base,
    output logic                    out_valid,
    output logic                    out_sop,
    output logic                    out_eop,
    output logic                    err_abort,
    output logic                    busy
`ifdef FFT_CTRL_STATS_EN
    ,
    output logic [15:0]             frame_cnt,
    output logic [7:0]              abort_cnt
`endif
);

    localparam int COUNT  = DATA / NUM;
    localparam int HALF   = COUNT / 2;
    localparam int TW_W   = $clog2(DATA);
    localparam int IDX_W  = (COUNT > 1) ? $clog2(COUNT) : 1;
    localparam int PEND_W = $clog2(HALF + 1);

    localparam logic [IDX_W-1:0]  HALF_IDX  = IDX_W'(HALF);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(COUNT - 1);
    localparam logic [IDX_W-1:0]  IDX_ONE   = IDX_W'(1);
    localparam logic [PEND_W-1:0] HALF_PEND = PEND_W'(HALF);
    localparam logic [PEND_W-1:0] PEND_ONE  = PEND_W'(1);

    import fft_pkg::*;

    fft_ctrl_state_t   state, state_nxt;
    logic [IDX_W-1:0]  beat_cnt, beat_nxt;
    logic [PEND_W-1:0] pend_cnt, pend_nxt;
    logic [IDX_W-1:0]  out_idx;
    logic              accept, owe_issue, low_issue, pipe_busy;
    ctrl_tag_t         tag_in, tag_out;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            beat_cnt <= '0;
            pend_cnt <= '0;
        end else begin
            state    <= state_nxt;
            beat_cnt <= beat_nxt;
            pend_cnt <= pend_nxt;
        end
    end

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        state_nxt = state;
        beat_nxt  = beat_cnt;
        pend_nxt  = pend_cnt;
        in_ready  = 1'b1;
        accept    = 1'b0;
        owe_issue = 1'b0;
        low_issue = 1'b0;
        err_abort = 1'b0;
        dp_issue  = 1'b0;
        dp_sel    = 1'b0;
        out_idx   = '0;
        busy      = 1'b0;
        if (!rst) begin
            in_ready  = (state != FLUSH);
            accept    = in_ready && in_valid;
            owe_issue = (pend_cnt != '0);
            low_issue = accept && (beat_cnt >= HALF_IDX);
            busy      = (state != IDLE) || pipe_busy;
            if (owe_issue) pend_nxt = pend_cnt - PEND_ONE;
            if (accept)    beat_nxt = (beat_cnt == LAST_IDX) ? '0 : beat_cnt + IDX_ONE;

            unique case (state)
                IDLE: if (accept) state_nxt = RUN;
                RUN: begin
                    if (accept && beat_cnt == LAST_IDX) begin
                        pend_nxt  = HALF_PEND;
                        state_nxt = TAIL;
                    end else if (!in_valid && beat_cnt != '0) begin
                        // Partial frame: drop its remaining lows, still drain owed highs.
                        err_abort = 1'b1;
                        beat_nxt  = '0;
                        state_nxt = (pend_nxt != '0) ? FLUSH : IDLE;
                    end
                end
                TAIL:  state_nxt = in_valid ? RUN : ((pend_nxt != '0) ? FLUSH : IDLE);
                FLUSH: if (pend_nxt == '0) state_nxt = IDLE;
            endcase

            dp_issue = owe_issue || low_issue;
            dp_sel   = low_issue && !owe_issue;
            if (owe_issue)      out_idx = IDX_W'(COUNT - int'(pend_cnt));
            else if (low_issue) out_idx = beat_cnt - HALF_IDX;
        end
    end

    assign dp_tw_base = TW_W'(int'(out_idx) * NUM);

    assign tag_in = '{valid: dp_issue,
                      sop:   dp_issue && (out_idx == '0),
                      eop:   dp_issue && (out_idx == LAST_IDX)};

    ctrl_delay_line #(.LAT(LAT)) u_delay (
        .clk       (clk),
        .rst       (rst),
        .din       (tag_in),
        .dout      (tag_out),
        .any_valid (pipe_busy)
    );

    assign out_valid = tag_out.valid && !rst;
    assign out_sop   = tag_out.sop   && !rst;
    assign out_eop   = tag_out.eop   && !rst;

    a_no_issue_clash: assert property (@(posedge clk) disable iff (rst) !(owe_issue && low_issue));

`ifdef FFT_CTRL_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt <= '0;
            abort_cnt <= '0;
        end else begin
            if (out_eop && frame_cnt != '1)   frame_cnt <= frame_cnt + 16'd1;
            if (err_abort && abort_cnt != '1) abort_cnt <= abort_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fft_stage_ctrl.sv
// Directed bench for fft_stage_ctrl (NUM=16, DATA=128, LAT=4): per-cycle output
// masks and twiddle sequences compared against hand-derived expectations.
module tb_fft_stage_ctrl;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic       dp_sel;
    logic       dp_issue;
    logic [6:0] dp_tw_base;
    logic       out_valid;
    logic       out_sop;
    logic       out_eop;
    logic       err_abort;
    logic       busy;
`ifdef FFT_CTRL_STATS_EN
    logic [15:0] frame_cnt;
    logic [7:0]  abort_cnt;
`endif

    int total = 0;
    int bad   = 0;

    logic [63:0] r_issue, r_sel, r_ov, r_sop, r_eop, r_abort, r_ready, r_busy, r_twz;
    int tw_got[$];
    int tw_exp[$];

    fft_stage_ctrl #(.NUM(16), .DATA(128), .LAT(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .dp_sel     (dp_sel),
        .dp_issue   (dp_issue),
        .dp_tw_base (dp_tw_base),
        .out_valid  (out_valid),
        .out_sop    (out_sop),
        .out_eop    (out_eop),
        .err_abort  (err_abort),
        .busy       (busy)
`ifdef FFT_CTRL_STATS_EN
        ,
        .frame_cnt  (frame_cnt),
        .abort_cnt  (abort_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] rng(input int lo, input int hi);
        logic [63:0] m = '0;
        for (int i = lo; i <= hi; i++) m[i] = 1'b1;
        return m;
    endfunction

    // Cycle c: inputs applied 1 ns after a rising edge, outputs sampled mid-cycle.
    task automatic run(input logic [63:0] vm, input logic [63:0] rm, input int ncyc);
        {r_issue, r_sel, r_ov, r_sop, r_eop} = '0;
        {r_abort, r_ready, r_busy, r_twz}    = '0;
        tw_got.delete();
        for (int c = 0; c < ncyc; c++) begin
            in_valid = vm[c];
            rst      = rm[c];
            #4;
            r_issue[c] = dp_issue;
            r_sel[c]   = dp_sel;
            r_ov[c]    = out_valid;
            r_sop[c]   = out_sop;
            r_eop[c]   = out_eop;
            r_abort[c] = err_abort;
            r_ready[c] = in_ready;
            r_busy[c]  = busy;
            r_twz[c]   = !dp_issue && (dp_tw_base != '0);
            if (dp_issue) tw_got.push_back(int'(dp_tw_base));
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        rst      = 1'b0;
    endtask

    task automatic check_run(input string s,
                             input logic [63:0] e_issue, input logic [63:0] e_sel,
                             input logic [63:0] e_ov,    input logic [63:0] e_sop,
                             input logic [63:0] e_eop,   input logic [63:0] e_abort,
                             input logic [63:0] e_ready, input logic [63:0] e_busy);
        int n;
        check({s, ".issue"}, r_issue, e_issue);
        check({s, ".sel"},   r_sel,   e_sel);
        check({s, ".ov"},    r_ov,    e_ov);
        check({s, ".sop"},   r_sop,   e_sop);
        check({s, ".eop"},   r_eop,   e_eop);
        check({s, ".abort"}, r_abort, e_abort);
        check({s, ".ready"}, r_ready, e_ready);
        check({s, ".busy"},  r_busy,  e_busy);
        check({s, ".twz"},   r_twz,   64'd0);
        check({s, ".tw_n"},  64'(tw_got.size()), 64'(tw_exp.size()));
        n = (tw_got.size() < tw_exp.size()) ? tw_got.size() : tw_exp.size();
        for (int i = 0; i < n; i++)
            check($sformatf("%s.tw%0d", s, i), 64'(tw_got[i]), 64'(tw_exp[i]));
    endtask

    task automatic push_frame_tw();
        for (int i = 0; i < 8; i++) tw_exp.push_back(i * 16);
    endtask

    task automatic scen_single(input string s);
        tw_exp.delete();
        push_frame_tw();
        run(rng(0, 7), '0, 24);
        check_run(s, rng(4, 11), rng(4, 7), rng(8, 15), rng(8, 8), rng(15, 15), '0,
                  rng(0, 23) & ~rng(9, 11), rng(1, 15));
    endtask

    task automatic scen_abort();
        tw_exp.delete();
        push_frame_tw();
        tw_exp.push_back(0);
        run(rng(0, 12), '0, 32);
        check_run("abort", rng(4, 12), rng(4, 7) | rng(12, 12), rng(8, 16),
                  rng(8, 8) | rng(16, 16), rng(15, 15), rng(13, 13), rng(0, 31), rng(1, 16));
    endtask

    task automatic scen_three();
        tw_exp.delete();
        repeat (3) push_frame_tw();
        run(rng(0, 23), '0, 40);
        check_run("three", rng(4, 27), rng(4, 7) | rng(12, 15) | rng(20, 23), rng(8, 31),
                  rng(8, 8) | rng(16, 16) | rng(24, 24), rng(15, 15) | rng(23, 23) | rng(31, 31),
                  '0, rng(0, 39) & ~rng(25, 27), rng(1, 31));
    endtask

    task automatic scen_flush_hold();
        tw_exp.delete();
        repeat (2) push_frame_tw();
        run(rng(0, 7) | rng(9, 19), '0, 40);
        check_run("flush", rng(4, 11) | rng(16, 23), rng(4, 7) | rng(16, 19),
                  rng(8, 15) | rng(20, 27), rng(8, 8) | rng(20, 20), rng(15, 15) | rng(27, 27),
                  '0, rng(0, 39) & ~rng(9, 11) & ~rng(21, 23), rng(1, 27));
    endtask

    task automatic scen_reset_mid();
        tw_exp.delete();
        tw_exp.push_back(0);
        tw_exp.push_back(16);
        run(rng(0, 6), rng(6, 6), 20);
        check_run("rstmid", rng(4, 5), rng(4, 5), '0, '0, '0, '0, rng(0, 19), rng(1, 5));
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst.flags", 64'({in_ready, dp_issue, dp_sel, out_valid, out_sop, out_eop,
                                err_abort, busy}), 64'h80);
        check("rst.tw", 64'(dp_tw_base), 64'd0);
        rst = 1'b0;
        #4;
        check("idle.flags", 64'({in_ready, dp_issue, dp_sel, out_valid, out_sop, out_eop,
                                 err_abort, busy}), 64'h80);
        @(posedge clk);
        #1;

        scen_single("single");
        scen_abort();
        scen_single("single2");
`ifdef FFT_CTRL_STATS_EN
        check("stats.frames", 64'(frame_cnt), 64'd3);
        check("stats.aborts", 64'(abort_cnt), 64'd1);
`endif
        scen_three();
        scen_flush_hold();
        scen_reset_mid();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fft_stage_ctrl.md
FFT_STAGE_CTRL -- requirements
Module: fft_stage_ctrl

Interface
REQ-001 The block SHALL have parameter NUM, default 16, meaning parallel lanes per beat.
REQ-002 The block SHALL have parameter DATA, default 128, meaning points per frame.
REQ-003 The block SHALL have parameter LAT, default 4, meaning datapath cycles from issue to result.
REQ-004 The block SHALL derive COUNT = DATA/NUM beats per frame and HALF = COUNT/2.
REQ-005 The block SHALL have one clock and a synchronous, active-high reset: clk input 1 (all logic on rising edge); rst input 1 (synchronous, active-high).
REQ-006 The block SHALL have the upstream ports: in_valid input 1 (beat offered); in_ready output 1 (beat accepted when in_valid & in_ready).
REQ-007 The block SHALL have the datapath control ports: dp_sel output 1 (1 = butterfly low result, 0 = delayed high result); dp_issue output 1 (result beat issued this cycle); dp_tw_base output $clog2(DATA) (twiddle base = out_idx*NUM).
REQ-008 The block SHALL have the downstream status ports: out_valid output 1 (dp_issue delayed LAT cycles); out_sop output 1 (out_idx 0, delayed LAT); out_eop output 1 (out_idx COUNT-1, delayed LAT).
REQ-009 The block SHALL have the status ports: err_abort output 1 (one-cycle pulse on aborted frame); busy output 1 (state != IDLE or any pipeline stage valid).

Function
REQ-010 The FSM SHALL have four states: IDLE, RUN, TAIL and FLUSH.
REQ-011 beat_cnt (0..COUNT-1) SHALL increment on each accepted beat, wrap to 0 after COUNT-1, and force TAIL.
REQ-012 pend_cnt (0..HALF) SHALL count high halves still owed from the previous frame.
REQ-013 Accepted beat with beat_cnt >= HALF: dp_issue=1, dp_sel=1, out_idx = beat_cnt-HALF.
REQ-014 Owed high issue (pend_cnt>0): dp_issue=1, dp_sel=0, out_idx = COUNT-pend_cnt, then pend_cnt decrements; takes precedence for dp_sel over REQ-013 (cannot coincide by construction, and an assertion SHALL check this).
REQ-015 Accepted beat with beat_cnt < HALF and pend_cnt=0: dp_issue=0, dp_sel=0.
REQ-016 IDLE: in_ready=1; in_valid causes beat 0 to be accepted, then RUN.
REQ-017 RUN: in_ready=1; acceptance of beat COUNT-1 sets pend_cnt=HALF, then TAIL.
REQ-018 TAIL: in_ready=1; in_valid causes beat 0 of the next frame to be accepted, the first owed high to be issued, then RUN; !in_valid causes the first owed high to be issued, then FLUSH.
REQ-019 FLUSH: in_ready=0; issues the remaining owed highs on consecutive cycles, then IDLE when pend_cnt reaches 0; in_valid is ignored.
REQ-020 Abort: in RUN with !in_valid and beat_cnt != 0, err_abort SHALL pulse, beat_cnt SHALL become 0, and no further low issues SHALL occur for that frame.
REQ-021 After an abort the state SHALL go to FLUSH if pend_cnt>0, else IDLE.
REQ-022 A continuous in_valid stream SHALL give dp_issue=1 every cycle from beat HALF of frame 0 onward, with no bubbles.
REQ-023 dp_tw_base SHALL be 0 when dp_issue=0.
REQ-024 out_valid/out_sop/out_eop SHALL be exactly dp_issue/(out_idx==0)/(out_idx==COUNT-1) delayed LAT cycles.

Reset
REQ-025 While rst=1 at a clock edge: state=IDLE, beat_cnt=0, pend_cnt=0, and delay pipeline cleared.
REQ-026 During and after reset, all outputs SHALL be 0 except in_ready=1.
REQ-027 Reset mid-frame SHALL discard all owed and in-flight beats with no err_abort pulse.

Configuration
REQ-028 With FFT_CTRL_STATS_EN defined, the block SHALL add outputs frame_cnt [15:0] (increments on out_eop) and abort_cnt [7:0] (increments on err_abort).
REQ-029 Both counters SHALL saturate and be cleared by rst.
REQ-030 Without FFT_CTRL_STATS_EN, these ports and their logic SHALL be absent.

Structure
REQ-031 Package fft_pkg SHALL hold NUM, DATA, COUNT, HALF and the state enum type fft_ctrl_state_t.
REQ-032 Sub-module ctrl_delay_line SHALL implement a LAT-deep, 3-bit-wide shift register {valid,sop,eop} with synchronous reset.

Verification
REQ-033 Single frame (in_valid 8 cycles, DATA=128): dp_issue cycles 4..11, with dp_sel=1 on cycles 4-7 and 0 on cycles 8-11; dp_tw_base = 0,16,...,112; FLUSH on cycles 9-11; out_valid on cycles 8..15.
REQ-034 Three back-to-back frames (24 cycles valid): dp_issue continuous on cycles 4..27; out_sop at cycles 8, 16, 24; out_eop at cycles 15, 23, 31.
REQ-035 in_valid drops at beat 5 of frame 1 (after full frame 0): err_abort pulses once; the frame-0 highs still issue (dp_tw_base 64..112); no further frame-1 lows are issued; ends in IDLE.
REQ-036 in_valid held high during FLUSH: in_ready=0 on those cycles; no beat counted; the next frame starts in IDLE.
REQ-037 rst asserted at beat 6: next cycle all outputs are 0 and in_ready=1; no out_valid follows.
REQ-038 STATS build, 3 frames plus 1 abort: frame_cnt=3 and abort_cnt=1.
